// File: rtl/bram_stream_loader_if.sv
// Bus bundle between the stream loader and its surroundings: AXI-Stream
// operand input, BRAM port-1 write port, multiplier handshake and status.
interface bram_stream_loader_if #(
  parameter int BRAM_DW = 64,
  parameter int BRAM_AW = 10
) ();

  logic               start;
  logic [BRAM_DW-1:0] s_axis_tdata;
  logic               s_axis_tvalid;
  logic               s_axis_tready;
  logic               s_axis_tlast;
  logic [BRAM_AW-1:0] bram_addr;
  logic [BRAM_DW-1:0] bram_wrdata;
  logic               bram_en_a;
  logic               bram_we_a;
  logic               bram_en_b;
  logic               bram_we_b;
  logic               mm_start;
  logic               mm_finish;
  logic               busy;
  logic               done;
  logic               err_len;

  // Loader side
  modport master (
    input  start, s_axis_tdata, s_axis_tvalid, s_axis_tlast, mm_finish,
    output s_axis_tready, bram_addr, bram_wrdata, bram_en_a, bram_we_a,
           bram_en_b, bram_we_b, mm_start, busy, done, err_len
  );

  // Environment side (stream source, BRAMs, multiplier, controller)
  modport slave (
    output start, s_axis_tdata, s_axis_tvalid, s_axis_tlast, mm_finish,
    input  s_axis_tready, bram_addr, bram_wrdata, bram_en_a, bram_we_a,
           bram_en_b, bram_we_b, mm_start, busy, done, err_len
  );

endinterface

// File: rtl/bram_stream_loader.sv
// Streams WORDS_A + WORDS_B operand beats into two BRAMs through port 1,
// then kicks the matrix multiplier and waits for it to finish.
// All outputs come straight from flops; nothing combinational reaches a port.
module bram_stream_loader #(
  parameter int BRAM_DW = 64,
  parameter int BRAM_AW = 10,
  parameter int WORDS_A = 512,
  parameter int WORDS_B = 512
) (
  input logic                  clk,
  input logic                  rst,
  bram_stream_loader_if.master bus
);

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StLoadA  = 3'd1;
  localparam logic [2:0] StLoadB  = 3'd2;
  localparam logic [2:0] StKick   = 3'd3;
  localparam logic [2:0] StWaitMm = 3'd4;
  localparam logic [2:0] StDone   = 3'd5;

  localparam logic [BRAM_AW-1:0] LastA = BRAM_AW'(WORDS_A - 1);
  localparam logic [BRAM_AW-1:0] LastB = BRAM_AW'(WORDS_B - 1);

  logic [2:0]         r_state;
  logic [2:0]         w_state_d;
  logic [BRAM_AW-1:0] r_cnt;
  logic [BRAM_AW-1:0] w_cnt_d;
  logic               w_accept;
  logic               w_err_set;
  logic               w_start_ok;

  logic               r_tready;
  logic               r_busy;
  logic               r_done;
  logic               r_mm_start;
  logic               r_err;
  logic               r_wr_a;
  logic               r_wr_b;
  logic [BRAM_AW-1:0] r_addr;
  logic [BRAM_DW-1:0] r_wrdata;

  // tready is high exactly in the load states, so acceptance keys off the state
  assign w_accept   = ((r_state == StLoadA) || (r_state == StLoadB)) && bus.s_axis_tvalid;
  assign w_start_ok = (r_state == StIdle) && bus.start;

  // Next-state, beat counter and framing-error detection
  always_comb begin
    w_state_d = r_state;
    w_cnt_d   = r_cnt;
    w_err_set = 1'b0;
    case (r_state)
      StIdle: begin
        if (bus.start) begin
          w_state_d = StLoadA;
          w_cnt_d   = '0;
        end
      end
      StLoadA: begin
        if (w_accept) begin
          if (bus.s_axis_tlast) begin
            // Any tlast inside matrix A is early: abort without kicking
            w_err_set = 1'b1;
            w_state_d = StDone;
          end else if (r_cnt == LastA) begin
            w_state_d = StLoadB;
            w_cnt_d   = '0;
          end else begin
            w_cnt_d = r_cnt + BRAM_AW'(1);
          end
        end
      end
      StLoadB: begin
        if (w_accept) begin
          if (r_cnt == LastB) begin
            // Missing tlast on the final beat is flagged but not fatal
            w_err_set = !bus.s_axis_tlast;
            w_state_d = StKick;
            w_cnt_d   = '0;
          end else if (bus.s_axis_tlast) begin
            w_err_set = 1'b1;
            w_state_d = StDone;
          end else begin
            w_cnt_d = r_cnt + BRAM_AW'(1);
          end
        end
      end
      StKick:   w_state_d = StWaitMm;
      StWaitMm: if (bus.mm_finish) w_state_d = StDone;
      StDone:   w_state_d = StIdle;
      default:  w_state_d = StIdle;
    endcase
  end

  // State, counter and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= StIdle;
      r_cnt      <= '0;
      r_tready   <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_mm_start <= 1'b0;
      r_err      <= 1'b0;
      r_wr_a     <= 1'b0;
      r_wr_b     <= 1'b0;
      r_addr     <= '0;
      r_wrdata   <= '0;
    end else begin
      r_state  <= w_state_d;
      r_cnt    <= w_cnt_d;
      r_tready <= (w_state_d == StLoadA) || (w_state_d == StLoadB);
      r_busy   <= (w_state_d != StIdle);
      r_done   <= (w_state_d == StDone);
      // Lags KICK by one cycle so the last B write lands before the multiplier starts
      r_mm_start <= (r_state == StKick);
      r_wr_a     <= w_accept && (r_state == StLoadA);
      r_wr_b     <= w_accept && (r_state == StLoadB);
      if (w_accept) begin
        r_addr   <= r_cnt;
        r_wrdata <= bus.s_axis_tdata;
      end
      if (w_start_ok) begin
        r_err <= 1'b0;
      end else if (w_err_set) begin
        r_err <= 1'b1;
      end
    end
  end

  assign bus.s_axis_tready = r_tready;
  assign bus.bram_addr     = r_addr;
  assign bus.bram_wrdata   = r_wrdata;
  assign bus.bram_en_a     = r_wr_a;
  assign bus.bram_we_a     = r_wr_a;
  assign bus.bram_en_b     = r_wr_b;
  assign bus.bram_we_b     = r_wr_b;
  assign bus.mm_start      = r_mm_start;
  assign bus.busy          = r_busy;
  assign bus.done          = r_done;
  assign bus.err_len       = r_err;

endmodule

// File: tb/tb_bram_stream_loader.sv
// Scoreboard bench for bram_stream_loader: the stimulus side pushes expected
// BRAM writes and control events, a negedge monitor pops and compares them.
module tb_bram_stream_loader;

  localparam int DW    = 64;
  localparam int AW    = 10;
  localparam int WA    = 512;
  localparam int WB    = 512;
  localparam int TOTAL = WA + WB;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bram_stream_loader_if #(.BRAM_DW(DW), .BRAM_AW(AW)) bus ();

  bram_stream_loader #(
    .BRAM_DW(DW),
    .BRAM_AW(AW),
    .WORDS_A(WA),
    .WORDS_B(WB)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    bit          sel;   // 0 = BRAM A, 1 = BRAM B
    int          addr;
    logic [DW-1:0] data;
  } wr_t;

  typedef struct {
    int kind;           // 1 = mm_start, 2 = done
    bit err;
  } ev_t;

  wr_t wr_q[$];
  ev_t ev_q[$];

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  logic [DW-1:0] mem_a [WA];
  logic [DW-1:0] mem_b [WB];
  int n_wr, last_wr_cyc, mm_cyc, done_cyc, mm_count, busy_low;
  bit seen_mm, seen_done, run_err;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(input string name, input logic [63:0] act,
                                input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Monitor: every DUT write or pulse must match the head of its queue
  always @(negedge clk) begin
    wr_t w;
    ev_t e;
    if (bus.bram_en_a || bus.bram_en_b) begin
      n_wr++;
      last_wr_cyc = cyc;
      check("we_a_eq_en_a", bus.bram_we_a, bus.bram_en_a);
      check("we_b_eq_en_b", bus.bram_we_b, bus.bram_en_b);
      check("single_bank", bus.bram_en_a && bus.bram_en_b, 0);
      check("write_expected", wr_q.size() != 0, 1);
      if (wr_q.size() != 0) begin
        w = wr_q.pop_front();
        check("write_bank", bus.bram_en_b, w.sel);
        check("write_addr", bus.bram_addr, w.addr);
        check("write_data", bus.bram_wrdata, w.data);
      end
      if (bus.bram_en_a) mem_a[bus.bram_addr[8:0]] = bus.bram_wrdata;
      else               mem_b[bus.bram_addr[8:0]] = bus.bram_wrdata;
    end
    if (bus.mm_start) begin
      seen_mm = 1;
      mm_cyc  = cyc;
      mm_count++;
      check("mm_start_expected", ev_q.size() != 0, 1);
      if (ev_q.size() != 0) begin
        e = ev_q.pop_front();
        check("event_is_mm_start", e.kind, 1);
      end
    end
    if (bus.done) begin
      seen_done = 1;
      done_cyc  = cyc;
      check("done_expected", ev_q.size() != 0, 1);
      if (ev_q.size() != 0) begin
        e = ev_q.pop_front();
        check("event_is_done", e.kind, 2);
        check("err_len_at_done", bus.err_len, e.err);
      end
    end
  end

  task automatic align();
    @(posedge clk);
    #1;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_tready"}, bus.s_axis_tready, 0);
    check({tag, "_busy"}, bus.busy, 0);
    check({tag, "_addr"}, bus.bram_addr, 0);
    check({tag, "_wrdata"}, bus.bram_wrdata, 0);
    check({tag, "_en_we"}, {bus.bram_en_a, bus.bram_we_a, bus.bram_en_b, bus.bram_we_b}, 0);
    check({tag, "_mm_start"}, bus.mm_start, 0);
    check({tag, "_done"}, bus.done, 0);
    check({tag, "_err_len"}, bus.err_len, 0);
  endtask

  task automatic clear_run();
    n_wr = 0; mm_count = 0; seen_mm = 0; seen_done = 0;
    mm_cyc = -1; done_cyc = -1; last_wr_cyc = -1;
    for (int k = 0; k < WA; k++) mem_a[k] = '1;
    for (int k = 0; k < WB; k++) mem_b[k] = '1;
  endtask

  // Called at posedge+1; start is high for exactly one cycle
  task automatic do_start();
    bus.start = 1'b1;
    align();
    bus.start = 1'b0;
  endtask

  // Reference model: global beat g lands in A[g] or B[g-WA] with data g
  task automatic run_beats(input int tlast_idx, input int duty, input int rst_at,
                           input int start_at, input int fin_at);
    int  g = 0;
    int  budget = 0;
    int  exp_g;
    bit  stop = 0;
    bit  start_done = 0;
    bit  fin_done = 0;
    wr_t w;
    ev_t e;
    busy_low = 0;
    run_err  = 0;
    while (!stop && g < TOTAL && budget < 20000) begin
      budget++;
      bus.s_axis_tvalid = ($urandom_range(99) < duty);
      bus.s_axis_tdata  = DW'(g);
      bus.s_axis_tlast  = (g == tlast_idx);
      if (g == start_at && !start_done) begin bus.start = 1'b1; start_done = 1; end
      if (g == fin_at && !fin_done) begin bus.mm_finish = 1'b1; fin_done = 1; end
      if (g == rst_at) begin bus.s_axis_tvalid = 1'b1; rst = 1'b1; end
      @(negedge clk);
      if (!bus.busy) busy_low++;
      if (rst) begin
        stop = 1;
      end else if (bus.s_axis_tvalid && bus.s_axis_tready) begin
        w.sel  = (g >= WA);
        w.addr = w.sel ? g - WA : g;
        w.data = DW'(g);
        wr_q.push_back(w);
        if (bus.s_axis_tlast && g != TOTAL - 1) begin
          run_err = 1;
          e.kind = 2; e.err = 1;
          ev_q.push_back(e);
          stop = 1;
        end else if (g == TOTAL - 1) begin
          if (!bus.s_axis_tlast) run_err = 1;
          e.kind = 1; e.err = 0;
          ev_q.push_back(e);
        end
        g++;
      end
      align();
      rst = 1'b0;
      bus.start = 1'b0;
      bus.mm_finish = 1'b0;
    end
    bus.s_axis_tvalid = 1'b0;
    bus.s_axis_tlast  = 1'b0;
    if (rst_at >= 0) exp_g = rst_at;
    else if (tlast_idx >= 0 && tlast_idx < TOTAL - 1) exp_g = tlast_idx + 1;
    else exp_g = TOTAL;
    check("beats_accepted", g, exp_g);
  endtask

  // Answers mm_start with mm_finish two cycles later and checks the done pulse
  task automatic finish_mm();
    int fin_cyc;
    int n = 0;
    ev_t e;
    do begin @(negedge clk); n++; end while (!seen_mm && n < 10);
    check("mm_start_pulsed", seen_mm, 1);
    check("mm_start_after_final_write", mm_cyc, last_wr_cyc + 1);
    do align(); while (cyc < mm_cyc + 2);
    e.kind = 2; e.err = run_err;
    ev_q.push_back(e);
    bus.mm_finish = 1'b1;
    fin_cyc = cyc;
    align();
    bus.mm_finish = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!seen_done && n < 10);
    check("done_pulsed", seen_done, 1);
    check("done_after_mm_finish", done_cyc, fin_cyc + 1);
    @(negedge clk);
    check("done_one_cycle", bus.done, 0);
    check("busy_low_in_idle", bus.busy, 0);
  endtask

  task automatic check_mems();
    int ok_a = 0;
    int ok_b = 0;
    for (int k = 0; k < WA; k++) if (mem_a[k] === DW'(k)) ok_a++;
    for (int k = 0; k < WB; k++) if (mem_b[k] === DW'(WA + k)) ok_b++;
    check("bram_a_contents", ok_a, WA);
    check("bram_b_contents", ok_b, WB);
  endtask

  task automatic check_drained(input string tag);
    check({tag, "_scoreboard_drained"}, wr_q.size() + ev_q.size(), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got still running expected finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int tr_hi;
    bus.start = 1'b0; bus.s_axis_tdata = '0; bus.s_axis_tvalid = 1'b0;
    bus.s_axis_tlast = 1'b0; bus.mm_finish = 1'b0;
    clear_run();

    // Reset state, then start on the very first cycle after release
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_zero("reset");
    align();
    rst = 1'b0;

    // V1: nominal back-to-back load
    do_start();
    run_beats(TOTAL - 1, 100, -1, -1, -1);
    finish_mm();
    check("v1_err_len", bus.err_len, 0);
    check("v1_write_count", n_wr, TOTAL);
    check_mems();
    check_drained("v1");

    // V2: 50% tvalid duty
    clear_run(); align();
    do_start();
    run_beats(TOTAL - 1, 50, -1, -1, -1);
    check("v2_busy_throughout", busy_low, 0);
    finish_mm();
    check("v2_write_count", n_wr, TOTAL);
    check_mems();
    check_drained("v2");

    // V3: early tlast on beat 600
    clear_run(); align();
    do_start();
    run_beats(600, 100, -1, -1, -1);
    repeat (3) @(negedge clk);
    check("v3_done_pulsed", seen_done, 1);
    check("v3_err_len", bus.err_len, 1);
    check("v3_b88", mem_b[88], DW'(600));
    check("v3_b89_untouched", mem_b[89], '1);
    align();
    bus.s_axis_tvalid = 1'b1;
    tr_hi = 0;
    for (int i = 0; i < 8; i++) begin @(negedge clk); if (bus.s_axis_tready) tr_hi++; end
    align();
    bus.s_axis_tvalid = 1'b0;
    check("v3_tready_low_after", tr_hi, 0);
    check("v3_no_mm_start", mm_count, 0);
    check("v3_write_count", n_wr, 601);
    check_drained("v3");

    // V4: no tlast anywhere
    clear_run(); align();
    do_start();
    run_beats(-1, 100, -1, -1, -1);
    finish_mm();
    check("v4_err_len_held", bus.err_len, 1);
    check_mems();
    check_drained("v4");

    // V5: reset in the middle of beat 300, then a clean reload
    clear_run(); align();
    do_start();
    @(negedge clk);
    check("v5_start_clears_err", bus.err_len, 0);
    align();
    run_beats(-1, 100, 300, -1, -1);
    @(negedge clk);
    check_zero("v5_after_rst");
    repeat (10) @(negedge clk);
    check("v5_writes_before_rst", n_wr, 300);
    check("v5_no_pulses", mm_count + (seen_done ? 1 : 0), 0);
    check_drained("v5_abort");
    clear_run(); align();
    do_start();
    run_beats(TOTAL - 1, 100, -1, -1, -1);
    finish_mm();
    check_mems();
    check_drained("v5_reload");

    // V6: start during LOAD_B and mm_finish during LOAD_A are ignored
    clear_run(); align();
    do_start();
    run_beats(TOTAL - 1, 100, -1, 700, 100);
    finish_mm();
    check("v6_single_mm_start", mm_count, 1);
    check("v6_err_len", bus.err_len, 0);
    check("v6_write_count", n_wr, TOTAL);
    check_mems();
    check_drained("v6");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/bram_stream_loader.md
BRAM_STREAM_LOADER -- requirements
Module: bram_stream_loader

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- BRAM_DW, 64, stream and BRAM word width
- BRAM_AW, 10, BRAM port-1 address width
- WORDS_A, 512, beats loaded into BRAM A (64x64 8-bit operands)
- WORDS_B, 512, beats loaded into BRAM B
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk, in, 1, single clock for all logic
- rst, in, 1, synchronous active-high reset
- start, in, 1, one-cycle load request
- s_axis_tdata, in, BRAM_DW, operand beat
- s_axis_tvalid, in, 1, beat valid
- s_axis_tready, out, 1, beat accepted when high with tvalid
- s_axis_tlast, in, 1, final beat marker
- bram_addr, out, BRAM_AW, port-1 write address
- bram_wrdata, out, BRAM_DW, port-1 write data
- bram_en_a, out, 1, BRAM A port-1 enable
- bram_we_a, out, 1, BRAM A port-1 write enable
- bram_en_b, out, 1, BRAM B port-1 enable
- bram_we_b, out, 1, BRAM B port-1 write enable
- mm_start, out, 1, one-cycle start pulse to Matrix_Multiply
- mm_finish, in, 1, Matrix_Multiply Finish level/pulse
- busy, out, 1, high in any state except IDLE
- done, out, 1, one-cycle completion pulse
- err_len, out, 1, sticky tlast-framing error

Function
REQ-003 The FSM SHALL have states IDLE, LOAD_A, LOAD_B, KICK, WAIT_MM and DONE.
REQ-004 IDLE SHALL move to LOAD_A on start=1, clear the beat counter and clear err_len.
REQ-005 The start input SHALL be ignored in every state other than IDLE.
REQ-006 s_axis_tready SHALL be 1 only in LOAD_A and LOAD_B.
REQ-007 A beat SHALL be accepted when tvalid and tready are both high.
REQ-008 A beat accepted in cycle t SHALL produce in cycle t+1 the following registered write, held for exactly one cycle:
- en=we=1 on the selected BRAM
- bram_addr = beat index within that matrix
- bram_wrdata = tdata
REQ-009 In cycles with no accepted beat, en and we SHALL be 0; bram_addr and bram_wrdata SHALL hold their last values.
REQ-010 The address counter SHALL increment once per accepted beat.
REQ-011 On the beat at index WORDS_A-1, the FSM SHALL move LOAD_A->LOAD_B and the counter SHALL wrap to 0.
REQ-012 On the beat at index WORDS_B-1 of LOAD_B, the FSM SHALL move LOAD_B->KICK.
REQ-013 tvalid gaps SHALL stall the counter and the FSM without any loss of beats.
REQ-014 KICK SHALL last one cycle, drive mm_start=1 and move to WAIT_MM.
REQ-015 The mm_start pulse SHALL follow the final BRAM B write by one cycle, so the final write completes before the multiplier starts.
REQ-016 WAIT_MM SHALL move to DONE on the first cycle in which mm_finish=1.
REQ-017 mm_finish SHALL be ignored in every state other than WAIT_MM.
REQ-018 DONE SHALL last one cycle, drive done=1 and move to IDLE.
REQ-019 Early tlast (tlast=1 on any accepted beat other than global beat WORDS_A+WORDS_B-1) SHALL:
- write that beat normally
- set err_len
- go to DONE, skipping KICK and WAIT_MM, so mm_start is never asserted
REQ-020 Missing tlast on global beat WORDS_A+WORDS_B-1 SHALL set err_len, and the flow SHALL otherwise proceed normally.
REQ-021 err_len SHALL hold until the next accepted start or until rst.
REQ-022 Every output SHALL be driven directly from a register; there SHALL be no combinational path from any input to any output.

Reset
REQ-023 rst=1 at a clk edge SHALL force, in any state:
- FSM to IDLE
- counter to 0
- all outputs to 0, including bram_addr, bram_wrdata and err_len
REQ-024 rst asserted during LOAD_A, LOAD_B or WAIT_MM SHALL abort the operation with no further BRAM writes and no mm_start or done pulse.
REQ-025 The first start SHALL be accepted on the cycle after rst deasserts.

Verification
REQ-026 The bench SHALL cover the following directed scenarios:
- V1, nominal: start, then 1024 back-to-back beats with tdata=index and tlast on beat 1023 -> BRAM A addr k holds k and BRAM B addr k holds 512+k for k=0..511; mm_start one cycle after the final write; mm_finish two cycles later -> done one cycle later; err_len=0.
- V2, stalls: random tvalid at 50% duty -> BRAM contents identical to V1; exactly 1024 writes; busy stays high throughout.
- V3, early tlast: tlast on beat 600 -> beat 600 written to B addr 88; err_len=1; done pulses; mm_start never asserted; tready=0 afterwards.
- V4, missing tlast: no tlast on any beat -> err_len=1; mm_start still pulses; done follows mm_finish.
- V5, mid-load reset: rst during beat 300 -> outputs 0 and no further writes; a new start reloads correctly, with addresses restarting at 0.
- V6, ignored inputs: start pulsed during LOAD_B and mm_finish pulsed during LOAD_A -> no state or output change.
